// File: rtl/matrix_wb_drain.sv
// Matrix-path producer for the writeback port: captures a packed block of results
// and drains it one element per cycle, yielding the port to the pipeline on conflict.
module matrix_wb_drain #(
  parameter int DATA_W      = 8,
  parameter int REG_W       = 3,
  parameter int DEPTH       = 4,
  parameter int STALL_AFTER = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W*DEPTH-1:0]   res_data,
  input  logic [REG_W-1:0]          base_reg,
  input  logic [2:0]                count,
  input  logic                      pipe_write,
  output logic [DATA_W-1:0]         wb_data,
  output logic [REG_W-1:0]          wb_destreg,
  output logic                      wb_write,
  output logic                      wb_sel,
  output logic                      stall_req,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, DRAIN, FIN} state_e;

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               BLK_W   = $clog2(STALL_AFTER + 1);
  localparam logic [2:0]       DEPTH_C = 3'(DEPTH);
  localparam logic [BLK_W-1:0] STALL_C = BLK_W'(STALL_AFTER);

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [REG_W-1:0]        base_q, base_d;
  logic [BLK_W-1:0]        blk_q, blk_d;
  logic [DATA_W-1:0]       buf_q [DEPTH];
  logic [DATA_W-1:0]       buf_d [DEPTH];
  logic                    grant;
  logic                    last;

  // The pipeline owns the port whenever it writes; we only drive on the idle slots.
  assign grant = (state_q == DRAIN) && !pipe_write;
  assign last  = (idx_q == cnt_q - 3'd1);

  // NOTE: the result buffer is cleared on reset along with the control state, so a
  // reset leaves no stale operands behind; non-blocking assignments throughout keep
  // every flop updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      blk_q   <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      blk_q   <= blk_d;
      buf_q   <= buf_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    blk_d   = blk_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < DEPTH; i++) buf_d[i] = res_data[i*DATA_W +: DATA_W];
          base_d  = base_reg;
          cnt_d   = (count > DEPTH_C) ? DEPTH_C : count;
          idx_d   = '0;
          blk_d   = '0;
          state_d = (count == 3'd0) ? FIN : DRAIN;
        end
      end
      DRAIN: begin
        if (grant) begin
          idx_d = idx_q + 3'd1;
          blk_d = '0;
          if (last) state_d = FIN;
        end else if (blk_q < STALL_C) begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Matrix leg outputs are zero unless we actually own the port, so the mux never
  // sees stale data.
  always_comb begin
    wb_sel     = 1'b0;
    wb_write   = 1'b0;
    wb_data    = '0;
    wb_destreg = '0;
    if (grant) begin
      wb_sel     = 1'b1;
      wb_write   = 1'b1;
      wb_data    = buf_q[idx_q[IDX_W-1:0]];
      wb_destreg = base_q + REG_W'(idx_q);
    end
    stall_req = (state_q == DRAIN) && (blk_q >= STALL_C);
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
  end

endmodule
